binary_to_bcd_seq: RTL and testbench

//  Parametrised, sequential binary-to-BCD converter using iterative double-dabble (shift-add-3).

---
 rtl/binary_to_bcd_seq.sv | 107 ++++++++++
 tb/tb_binary_to_bcd_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one operand bit per cycle, result BIN_W cycles after accept.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready, with no bypass.
module binary_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  if (BIN_W < 2) begin : g_bad_bin_w
    $error("binary_to_bcd_seq: BIN_W must be at least 2");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("binary_to_bcd_seq: DIGITS must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [BIN_W-1:0]   mag;
  logic [BCD_W-1:0]   digits;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               ovf;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   digits_nxt;
  logic               ovf_nxt;
  logic               take_neg;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign take_neg  = in_signed && in_bin[BIN_W-1];

  // Add-3 correction so each digit carries correctly into the next on the shift.
  always_comb begin
    adj = digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (digits[4*k +: 4] > 4'd4) begin
        adj[4*k +: 4] = digits[4*k +: 4] + 4'd3;
      end
    end
  end

  // A one leaving the top digit means the value no longer fits in DIGITS digits.
  assign digits_nxt = {adj[BCD_W-2:0], mag[BIN_W-1]};
  assign ovf_nxt    = ovf | adj[BCD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mag     <= '0;
      digits  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
      out_bcd <= '0;
      out_neg <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag    <= take_neg ? (~in_bin + BIN_W'(1)) : in_bin;
            neg    <= take_neg;
            digits <= '0;
            ovf    <= 1'b0;
            cnt    <= CNT_W'(BIN_W);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          digits <= digits_nxt;
          mag    <= {mag[BIN_W-2:0], 1'b0};
          ovf    <= ovf_nxt;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            out_bcd <= digits_nxt;
            out_ovf <= ovf_nxt;
            out_neg <= neg;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed and sweep bench for binary_to_bcd_seq (BIN_W=10 with DIGITS=4 and DIGITS=2 instances).
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_rdy = 1'b0;
  logic [9:0]  in_bin = '0;
  logic        in_signed = 1'b0;

  logic        rdy_a, rdy_b, vld_a, vld_b, neg_a, neg_b, ovf_a, ovf_b;
  logic [15:0] bcd_a;
  logic [7:0]  bcd_b;

  logic        rdy, ovld, oneg, oovf;
  logic [15:0] obcd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(rdy_a), .in_bin(in_bin), .in_signed(in_signed),
    .out_valid(vld_a), .out_ready(out_rdy & ~sel),
    .out_bcd(bcd_a), .out_neg(neg_a), .out_ovf(ovf_a)
  );

  binary_to_bcd_seq #(.BIN_W(10), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(rdy_b), .in_bin(in_bin), .in_signed(in_signed),
    .out_valid(vld_b), .out_ready(out_rdy & sel),
    .out_bcd(bcd_b), .out_neg(neg_b), .out_ovf(ovf_b)
  );

  assign rdy  = sel ? rdy_b : rdy_a;
  assign ovld = sel ? vld_b : vld_a;
  assign oneg = sel ? neg_b : neg_a;
  assign oovf = sel ? ovf_b : ovf_a;
  assign obcd = sel ? {8'h00, bcd_b} : bcd_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden model for the 4-digit instance: {neg, ovf, bcd}.
  function automatic logic [17:0] golden(input logic [9:0] b, input logic s);
    logic        n;
    int          v;
    logic [15:0] d;
    n = s & b[9];
    v = n ? (1024 - int'(b)) : int'(b);
    for (int k = 0; k < 4; k++) begin
      d[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {n, (v != 0), d};
  endfunction

  // Starts and ends at 1 time unit after a rising edge.
  task automatic convert(input logic [9:0] b, input logic s, output int lat);
    int guard;
    in_bin = b; in_signed = s; in_valid = 1'b1;
    guard = 0;
    while (!rdy && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!ovld && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [9:0] b, input logic s,
                          input logic [17:0] exp);
    int lat;
    convert(b, s, lat);
    check({tag, "_lat"}, 32'(lat), 32'd10);
    check(tag, {14'd0, oneg, oovf, obcd}, {14'd0, exp});
    drain();
  endtask

  logic [17:0] exp_q[$];
  int          received;
  int          cyc;

  task automatic produce();
    for (int i = 0; i < 2048; i++) begin
      int g;
      int guard;
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
      in_bin = 10'(i); in_signed = (i >= 1024); in_valid = 1'b1;
      guard = 0;
      while (!rdy && guard < 200) begin
        @(posedge clk); #1; guard++;
      end
      if (guard >= 200) begin
        check("sweep_in_timeout", 32'(rdy), 32'd1);
        in_valid = 1'b0;
        return;
      end
      exp_q.push_back(golden(in_bin, in_signed));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic consume();
    logic [17:0] e;
    cyc = 0;
    while (received < 2048 && cyc < 90000) begin
      out_rdy = 1'($urandom_range(0, 1));
      if (ovld && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("sweep_unexpected", {14'd0, oneg, oovf, obcd}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sweep", {14'd0, oneg, oovf, obcd}, {14'd0, e});
        end
        received++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_rdy = 1'b0;
  endtask

  initial begin
    logic [17:0] held;
    int lat;

    #2;
    check("rst_out_valid", 32'(vld_a), 32'd0);
    check("rst_outs", {14'd0, neg_a, ovf_a, bcd_a}, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(rdy_a), 32'd1);

    // Unsigned full scale, latency, and signed corners.
    directed("t1_1023", 10'd1023, 1'b0, {2'b00, 16'h1023});
    directed("t2_neg512", 10'h200, 1'b1, {2'b10, 16'h0512});
    directed("t2_neg1", 10'h3FF, 1'b1, {2'b10, 16'h0001});
    directed("t2_3ff_uns", 10'h3FF, 1'b0, {2'b00, 16'h1023});
    directed("t2_pos_signed", 10'd511, 1'b1, {2'b00, 16'h0511});
    directed("t1_zero", 10'd0, 1'b0, {2'b00, 16'h0000});

    // Two-digit instance: overflow boundary.
    sel = 1'b1;
    directed("t3_999", 10'd999, 1'b0, {2'b01, 16'h0099});
    directed("t3_99", 10'd99, 1'b0, {2'b00, 16'h0099});
    directed("t3_100", 10'd100, 1'b0, {2'b01, 16'h0000});
    directed("t3_neg100", 10'h39C, 1'b1, {2'b11, 16'h0000});
    sel = 1'b0;

    // Backpressure in DONE.
    convert(10'd987, 1'b0, lat);
    check("t4_lat", 32'(lat), 32'd10);
    held = {oneg, oovf, obcd};
    check("t4_result", {14'd0, held}, {14'd0, 2'b00, 16'h0987});
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 == 0);
      in_bin = 10'd5;
      @(posedge clk); #1;
      check("t4_hold", {12'd0, ovld, rdy, oneg, oovf, obcd}, {12'd0, 2'b10, held});
    end
    in_valid = 1'b0;
    drain();
    check("t4_release", {12'd0, ovld, rdy, oneg, oovf, obcd}, {12'd0, 2'b01, held});

    // Reset mid-conversion while the 4th bit is shifting.
    in_bin = 10'd777; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(vld_a), 32'd0);
    check("t5_rst_bcd", {14'd0, neg_a, ovf_a, bcd_a}, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_ready", 32'(rdy_a), 32'd1);
    directed("t5_zero", 10'd0, 1'b0, {2'b00, 16'h0000});

    // Sweep all operands in both modes with random handshake gaps.
    received = 0;
    fork
      produce();
      consume();
    join
    check("sweep_count", 32'(received), 32'd2048);
    check("sweep_leftover", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
